// File: rtl/aes128_rd_engine.sv
// CCI-P c0 read requester for the AES128 AFU: one read per 64B line, responses buffered in a
// credit-guarded FIFO and streamed downstream in arrival order, tagged with their line index.
module aes128_rd_engine #(
    parameter int FIFO_DEPTH = 64,
    parameter int IDX_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [41:0]        src_addr,
    input  logic [31:0]        num_lines,
    input  logic               c0_almfull,
    output logic               c0_req_valid,
    output logic [41:0]        c0_req_addr,
    output logic [15:0]        c0_req_mdata,
    input  logic               c0_rsp_valid,
    input  logic [15:0]        c0_rsp_mdata,
    input  logic [511:0]       c0_rsp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [511:0]       out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               busy,
    output logic               done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

    state_t            state;
    logic              start_q;
    logic [41:0]       base_addr;
    logic [31:0]       total;
    logic [31:0]       req_cnt;
    logic [31:0]       dlv_cnt;
    logic [CW-1:0]     credits;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [IDX_W+511:0] mem [FIFO_DEPTH];

    logic launch;
    logic issue;
    logic push;
    logic pop;
    logic empty;
    logic full;

    assign launch = start && !start_q && (state == IDLE || state == DONE);
    assign issue  = (state == REQ) && !c0_almfull && (credits != '0) && (req_cnt < total);
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Stale responses from a job killed by reset are dropped while idle.
    assign push   = c0_rsp_valid && (state != IDLE);
    assign pop    = !empty && out_ready;

    assign out_valid          = !empty;
    assign {out_idx, out_data} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {IDX_W'(c0_rsp_mdata), c0_rsp_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            base_addr    <= '0;
            total        <= '0;
            req_cnt      <= '0;
            dlv_cnt      <= '0;
            credits      <= CW'(FIFO_DEPTH);
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            c0_req_valid <= 1'b0;
            c0_req_addr  <= '0;
            c0_req_mdata <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            start_q      <= start;
            c0_req_valid <= issue;
            // One credit per free FIFO slot, so every outstanding read has a guaranteed landing spot.
            credits      <= credits - CW'(issue) + CW'(pop);
            if (issue) begin
                c0_req_addr  <= base_addr + 42'(req_cnt);
                c0_req_mdata <= req_cnt[15:0];
                req_cnt      <= req_cnt + 32'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                dlv_cnt <= dlv_cnt + 32'd1;
            end
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        base_addr <= src_addr;
                        total     <= num_lines;
                        req_cnt   <= '0;
                        dlv_cnt   <= '0;
                        done      <= (num_lines == '0);
                        busy      <= (num_lines != '0);
                        state     <= (num_lines == '0) ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (issue && (req_cnt + 32'd1 == total)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dlv_cnt == total) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: tb/tb_aes128_rd_engine.sv
// Directed bench for aes128_rd_engine: a small CCI-P responder plus request/output monitors,
// with hand-derived expectations checked by immediate assertions.
module tb_aes128_rd_engine;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [41:0]  src_addr;
    logic [31:0]  num_lines;
    logic         c0_almfull = 1'b0;
    logic         c0_req_valid;
    logic [41:0]  c0_req_addr;
    logic [15:0]  c0_req_mdata;
    logic         c0_rsp_valid;
    logic [15:0]  c0_rsp_mdata;
    logic [511:0] c0_rsp_data;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic [15:0]  out_idx;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int data_bad = 0;
    int af_viol = 0;
    int af_cnt = 0;
    logic af_toggle = 1'b0;
    logic af_edge = 1'b0;

    logic [41:0] req_addr_q[$];
    logic [15:0] req_md_q[$];
    logic [15:0] pend_q[$];
    logic [15:0] out_idx_q[$];

    aes128_rd_engine #(.FIFO_DEPTH(64), .IDX_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .num_lines(num_lines),
        .c0_almfull(c0_almfull), .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
        .c0_req_mdata(c0_req_mdata), .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata),
        .c0_rsp_data(c0_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] line_data(input logic [15:0] idx);
        return {16{16'hC0DE, idx}} ^ {8{64'h0123_4567_89AB_CDEF}};
    endfunction

    // almfull as the engine saw it on the most recent rising edge.
    always @(posedge clk) af_edge <= c0_almfull;

    always @(negedge clk) begin
        if (af_toggle) begin
            af_cnt = af_cnt + 1;
            if (af_cnt == 3) begin
                af_cnt = 0;
                c0_almfull = !c0_almfull;
            end
        end else begin
            af_cnt = 0;
            c0_almfull = 1'b0;
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (!reset && out_valid && out_ready) begin
            out_idx_q.push_back(out_idx);
            if (out_data !== line_data(out_idx)) data_bad++;
        end
        if (!reset && c0_req_valid) begin
            req_addr_q.push_back(c0_req_addr);
            req_md_q.push_back(c0_req_mdata);
            pend_q.push_back(c0_req_mdata);
            if (af_edge) af_viol++;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_bench();
        @(negedge clk);
        req_addr_q.delete();
        req_md_q.delete();
        pend_q.delete();
        out_idx_q.delete();
        data_bad = 0;
        af_viol = 0;
    endtask

    task automatic launch(input logic [41:0] a, input logic [31:0] n);
        @(negedge clk);
        src_addr = a;
        num_lines = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic run_responder(input string tag, input int total, input int budget);
        int cyc = 0;
        while (out_idx_q.size() < total && cyc < budget) begin
            @(negedge clk);
            if (pend_q.size() > 0) begin
                c0_rsp_valid = 1'b1;
                c0_rsp_mdata = pend_q.pop_front();
                c0_rsp_data  = line_data(c0_rsp_mdata);
            end else begin
                c0_rsp_valid = 1'b0;
            end
            cyc++;
        end
        @(negedge clk);
        c0_rsp_valid = 1'b0;
        check_output({tag, "_resp_timeout"}, 64'(cyc < budget), 64'd1);
    endtask

    task automatic respond_reversed();
        while (pend_q.size() > 0) begin
            @(negedge clk);
            c0_rsp_valid = 1'b1;
            c0_rsp_mdata = pend_q.pop_back();
            c0_rsp_data  = line_data(c0_rsp_mdata);
        end
        @(negedge clk);
        c0_rsp_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_output({tag, "_done"}, 64'(done), 64'd1);
        check_output({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reqs(input string tag, input logic [41:0] base, input int n);
        int bad = 0;
        check_output({tag, "_req_count"}, 64'(req_addr_q.size()), 64'(n));
        foreach (req_addr_q[i]) begin
            if (req_addr_q[i] !== base + 42'(i) || req_md_q[i] !== 16'(i)) bad++;
        end
        check_output({tag, "_req_seq_bad"}, 64'(bad), 64'd0);
        check_output({tag, "_almfull_viol"}, 64'(af_viol), 64'd0);
    endtask

    // The first rev outputs arrive reversed (rev-1 .. 0), the rest in request order.
    task automatic check_outs(input string tag, input int n, input int rev);
        int bad = 0;
        check_output({tag, "_out_count"}, 64'(out_idx_q.size()), 64'(n));
        foreach (out_idx_q[i]) begin
            if (out_idx_q[i] !== 16'((i < rev) ? (rev - 1 - i) : i)) bad++;
        end
        check_output({tag, "_out_order_bad"}, 64'(bad), 64'd0);
        check_output({tag, "_out_data_bad"}, 64'(data_bad), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        src_addr = '0;
        num_lines = '0;
        c0_rsp_valid = 1'b0;
        c0_rsp_mdata = '0;
        c0_rsp_data = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_output("rst_req_valid", 64'(c0_req_valid), 64'd0);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] zero-length job");
        clear_bench();
        launch(42'h5000, 32'd0);
        check_output("zero_done", 64'(done), 64'd1);
        check_output("zero_busy", 64'(busy), 64'd0);
        repeat (10) @(negedge clk);
        check_output("zero_req_count", 64'(req_addr_q.size()), 64'd0);

        $display("[TB] four-line job");
        clear_bench();
        out_ready = 1'b1;
        launch(42'h1000, 32'd4);
        check_output("t1_busy", 64'(busy), 64'd1);
        check_output("t1_done_cleared", 64'(done), 64'd0);
        run_responder("t1", 4, 200);
        wait_done("t1", 50);
        check_reqs("t1", 42'h1000, 4);
        check_outs("t1", 4, 0);

        $display("[TB] 200 lines, credit stall, reversed responses");
        clear_bench();
        out_ready = 1'b0;
        launch(42'h0, 32'd200);
        repeat (100) @(negedge clk);
        check_output("t2_stall_count", 64'(req_addr_q.size()), 64'd64);
        respond_reversed();
        repeat (5) @(negedge clk);
        #1;
        check_output("t2_still_64", 64'(req_addr_q.size()), 64'd64);
        check_output("t2_out_valid", 64'(out_valid), 64'd1);
        check_output("t2_head_idx", 64'(out_idx), 64'd63);
        check_output("t2_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        run_responder("t2", 200, 3000);
        wait_done("t2", 50);
        check_reqs("t2", 42'h0, 200);
        check_outs("t2", 200, 64);

        $display("[TB] almfull toggling");
        clear_bench();
        af_toggle = 1'b1;
        launch(42'h2000, 32'd50);
        run_responder("t3", 50, 2000);
        wait_done("t3", 50);
        af_toggle = 1'b0;
        check_reqs("t3", 42'h2000, 50);
        check_outs("t3", 50, 0);

        $display("[TB] address wrap");
        clear_bench();
        launch(42'h3FF_FFFF_FFFE, 32'd3);
        run_responder("t5", 3, 200);
        wait_done("t5", 50);
        check_output("t5_req_count", 64'(req_addr_q.size()), 64'd3);
        check_output("t5_addr0", 64'(req_addr_q[0]), 64'h3FF_FFFF_FFFE);
        check_output("t5_addr1", 64'(req_addr_q[1]), 64'h3FF_FFFF_FFFF);
        check_output("t5_addr2", 64'(req_addr_q[2]), 64'h0);
        check_outs("t5", 3, 0);

        $display("[TB] reset mid-job then clean rerun");
        clear_bench();
        out_ready = 1'b0;
        launch(42'h8000, 32'd40);
        for (int i = 0; i < 100 && req_addr_q.size() < 10; i++) @(negedge clk);
        check_output("t6_reached_10", 64'(req_addr_q.size() >= 10), 64'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_output("t6_rst_req_valid", 64'(c0_req_valid), 64'd0);
        check_output("t6_rst_busy", 64'(busy), 64'd0);
        check_output("t6_rst_done", 64'(done), 64'd0);
        check_output("t6_rst_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        c0_rsp_valid = 1'b1;
        c0_rsp_mdata = 16'd3;
        c0_rsp_data  = line_data(16'd3);
        repeat (2) @(negedge clk);
        c0_rsp_valid = 1'b0;
        #1;
        check_output("t6_stale_dropped", 64'(out_valid), 64'd0);
        clear_bench();
        out_ready = 1'b1;
        launch(42'h8000, 32'd40);
        run_responder("t6", 40, 1000);
        wait_done("t6", 50);
        check_reqs("t6", 42'h8000, 40);
        check_outs("t6", 40, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
